oled_spi_sequencer: RTL and testbench
=====================================

// Module: oled_spi_sequencer
// PURPOSE
//  Sequences the single-byte SPI sender for the 128x32 OLED: runs the power-up/init command
//  script, then on request streams a 512-byte frame buffer (4 pages x 128 columns).
//  Sits between the game renderer (frame-buffer RAM) and the SPI byte sender.
//  Owns the DC, RES, VBATC and VDDC panel pins.
// PARAMETERS
//  MS_CYCLES  100000  CLK cycles per 1 ms delay unit; bench uses 10
//  PAGES      4       display pages per frame
//  COLS       128     columns (bytes) per page
// PORTS
//  CLK         in   1  clock
//  RST         in   1  synchronous, active-high reset
//  INIT_START  in   1  pulse: run init script; ignored unless in OFF
//  UPDATE_REQ  in   1  pulse: send one full frame
//  BUSY        out  1  high while any script or frame transfer is in progress
//  INIT_DONE   out  1  high once the init script has completed; held until RST
//  FB_ADDR     out  9  frame-buffer read address = page*COLS + col
//  FB_DATA     in   8  frame-buffer read data; valid exactly 1 cycle after FB_ADDR
//  SPI_EN      out  1  byte request to the SPI sender
//  SPI_DATA    out  8  byte to send; stable while SPI_EN=1
//  SPI_FIN     in   1  sender done; stays high until SPI_EN drops
//  DC          out  1  0=command, 1=data; stable while SPI_EN=1
//  RES         out  1  panel reset, active-low
//  VBATC       out  1  panel VBAT enable, active-low
//  VDDC        out  1  logic VDD enable, active-low
// BEHAVIOUR
//  Reset values: SPI_EN=0 SPI_DATA=0 DC=0 RES=1 VBATC=1 VDDC=1 BUSY=0 INIT_DONE=0 FB_ADDR=0.
//  Reset also clears update_pending and returns the FSM to OFF. It takes effect mid-transfer:
//  SPI_EN drops the next cycle and no further bytes are sent.
//  Byte handshake:
//   - Drive SPI_DATA/DC and set SPI_EN=1 in the same cycle.
//   - Hold all three until SPI_FIN is sampled 1; clear SPI_EN the next cycle.
//   - Wait until SPI_FIN is sampled 0 (release).
//   - Next SPI_EN no earlier than the following cycle, so there is >=1 idle cycle with SPI_EN=0.
//  Delays: 32-bit down-counter loaded with N*MS_CYCLES-1. Exits on the cycle after it reads 0.
//  FSM states: OFF, INIT (script ROM step), SEND, WAIT_FIN, WAIT_REL, DELAY, READY,
//   PG_HDR, FB_FETCH, FB_SEND.
//  OFF -> INIT on INIT_START. BUSY=1 from the next cycle.
//  Init script, in order (cmd = DC=0 byte):
//   1. VDDC=0, delay 1 ms
//   2. cmd AE
//   3. RES=0, delay 1 ms; RES=1, delay 1 ms
//   4. cmd 8D 14 D9 F1
//   5. VBATC=0, delay 100 ms
//   6. cmd 81 0F A1 C8 DA 20 AF
//   7. INIT_DONE=1, BUSY=0 -> READY
//  READY -> frame transfer on UPDATE_REQ or update_pending. Clear pending on entry.
//  Frame transfer, for page p = 0..PAGES-1:
//   - PG_HDR: cmd 22, p, 00, 10.
//   - Then for col 0..COLS-1: FB_FETCH sets FB_ADDR=p*COLS+col.
//   - Next cycle, FB_SEND latches FB_DATA into SPI_DATA with DC=1 and runs the handshake.
//  After the last byte of page PAGES-1 (col wrap COLS-1 -> 0), return to READY.
//   BUSY=0 that cycle unless pending is set, in which case the next frame starts immediately.
//  UPDATE_REQ while a frame is in progress sets update_pending (one deep). Further
//   requests coalesce into it.
//  UPDATE_REQ before INIT_DONE: ignored, not stored. INIT_START outside OFF: ignored.
//  INIT_START and UPDATE_REQ in the same cycle in OFF: init starts, update ignored.
//  Total frame = PAGES*(4+COLS) = 528 SPI bytes.
// TESTING
//  1. Reset: hold RST 3 cycles -> all outputs at reset values. Idle 20 cycles, no SPI_EN.
//  2. INIT_START, MS_CYCLES=10, SPI model FIN 5 cycles after EN:
//     - byte order AE 8D 14 D9 F1 81 0F A1 C8 DA 20 AF, all DC=0
//     - RES low >=10 cycles; VBATC low >=1000 cycles before byte 81
//     - INIT_DONE=1 at end.
//  3. UPDATE_REQ after init with FB[i]=i[7:0]:
//     - 528 bytes; page 1 header = 22 01 00 10 then 80..FF with DC=1
//     - BUSY drops after the last byte.
//  4. UPDATE_REQ x3 during a frame -> exactly 2 frames total. UPDATE_REQ before init -> 0 bytes.
//  5. Stall SPI_FIN 50 cycles -> SPI_DATA/DC/SPI_EN unchanged. Next EN only after FIN seen 0.
//  6. RST asserted mid-page-2 -> SPI_EN=0 next cycle; state OFF, INIT_DONE=0, RES/VBATC/VDDC=1.

Source files
------------

// File: rtl/oled_spi_sequencer.sv
// oled_spi_sequencer
//   Drives a single-byte SPI sender for a 128x32 OLED panel. After INIT_START it
//   runs the panel power-up/init script (supply sequencing, reset pulse, command
//   bytes). Once initialised, each UPDATE_REQ streams one frame: a 4-byte page
//   header followed by COLS data bytes, repeated for every page. A request that
//   arrives mid-frame is held in a one-deep pending flag and starts the next frame.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   INIT_START        pulse, start init script (only honoured in OFF)
//   UPDATE_REQ        pulse, request one frame (only honoured after init)
//   BUSY              script or frame transfer in progress
//   INIT_DONE         init script finished, held until RST
//   FB_ADDR/FB_DATA   frame-buffer read port, data one cycle after address
//   SPI_EN/SPI_DATA   byte request and byte to the SPI sender
//   SPI_FIN           sender done, held high until SPI_EN drops
//   DC                0 = command byte, 1 = display data byte
//   RES/VBATC/VDDC    active-low panel reset and supply enables
module oled_spi_sequencer #(
    parameter int MS_CYCLES = 100000,
    parameter int PAGES     = 4,
    parameter int COLS      = 128
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INIT_START,
    input  logic       UPDATE_REQ,
    output logic       BUSY,
    output logic       INIT_DONE,
    output logic [8:0] FB_ADDR,
    input  logic [7:0] FB_DATA,
    output logic       SPI_EN,
    output logic [7:0] SPI_DATA,
    input  logic       SPI_FIN,
    output logic       DC,
    output logic       RES,
    output logic       VBATC,
    output logic       VDDC
);
    localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [3:0] {
        ST_OFF, ST_INIT, ST_SEND, ST_WAIT_FIN, ST_WAIT_REL,
        ST_DELAY, ST_READY, ST_PG_HDR, ST_FB_FETCH, ST_FB_SEND
    } state_t;

    // Init script opcodes: each ROM word is {opcode, argument}.
    localparam logic [2:0] OP_CMD     = 3'd0;
    localparam logic [2:0] OP_DLY     = 3'd1;  // argument = milliseconds
    localparam logic [2:0] OP_VDD_ON  = 3'd2;
    localparam logic [2:0] OP_RES_LO  = 3'd3;
    localparam logic [2:0] OP_RES_HI  = 3'd4;
    localparam logic [2:0] OP_VBAT_ON = 3'd5;
    localparam logic [2:0] OP_END     = 3'd6;

    function automatic logic [10:0] script_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    script_rom = {OP_VDD_ON,  8'h00};
            5'd1:    script_rom = {OP_DLY,     8'd1};
            5'd2:    script_rom = {OP_CMD,     8'hAE};
            5'd3:    script_rom = {OP_RES_LO,  8'h00};
            5'd4:    script_rom = {OP_DLY,     8'd1};
            5'd5:    script_rom = {OP_RES_HI,  8'h00};
            5'd6:    script_rom = {OP_DLY,     8'd1};
            5'd7:    script_rom = {OP_CMD,     8'h8D};
            5'd8:    script_rom = {OP_CMD,     8'h14};
            5'd9:    script_rom = {OP_CMD,     8'hD9};
            5'd10:   script_rom = {OP_CMD,     8'hF1};
            5'd11:   script_rom = {OP_VBAT_ON, 8'h00};
            5'd12:   script_rom = {OP_DLY,     8'd100};
            5'd13:   script_rom = {OP_CMD,     8'h81};
            5'd14:   script_rom = {OP_CMD,     8'h0F};
            5'd15:   script_rom = {OP_CMD,     8'hA1};
            5'd16:   script_rom = {OP_CMD,     8'hC8};
            5'd17:   script_rom = {OP_CMD,     8'hDA};
            5'd18:   script_rom = {OP_CMD,     8'h20};
            5'd19:   script_rom = {OP_CMD,     8'hAF};
            default: script_rom = {OP_END,     8'h00};
        endcase
    endfunction

    function automatic logic [8:0] fb_addr_of(input logic [PW-1:0] p, input logic [CW-1:0] c);
        return 9'(p) * 9'(COLS) + 9'(c);
    endfunction

    state_t        state_q, ret_q;
    logic [4:0]    step_q;
    logic [31:0]   delay_q;
    logic [PW-1:0] page_q;
    logic [CW-1:0] col_q;
    logic [1:0]    hdr_q;
    logic [7:0]    tx_byte_q;
    logic          tx_dc_q;
    logic          pending_q, pending_d;
    logic          busy_q, init_done_q, spi_en_q, dc_q, res_q, vbatc_q, vddc_q;
    logic [7:0]    spi_data_q;
    logic [8:0]    fb_addr_q;
    logic [2:0]    op;
    logic [7:0]    arg;

    assign {op, arg} = script_rom(step_q);

    // Requests are only remembered after init and while a frame is running;
    // in READY the request starts the frame directly.
    assign pending_d = pending_q | (UPDATE_REQ & init_done_q & (state_q != ST_READY));

    assign BUSY      = busy_q;
    assign INIT_DONE = init_done_q;
    assign FB_ADDR   = fb_addr_q;
    assign SPI_EN    = spi_en_q;
    assign SPI_DATA  = spi_data_q;
    assign DC        = dc_q;
    assign RES       = res_q;
    assign VBATC     = vbatc_q;
    assign VDDC      = vddc_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_OFF;
            ret_q       <= ST_OFF;
            step_q      <= '0;
            delay_q     <= '0;
            page_q      <= '0;
            col_q       <= '0;
            hdr_q       <= '0;
            tx_byte_q   <= '0;
            tx_dc_q     <= 1'b0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            spi_en_q    <= 1'b0;
            spi_data_q  <= '0;
            dc_q        <= 1'b0;
            res_q       <= 1'b1;
            vbatc_q     <= 1'b1;
            vddc_q      <= 1'b1;
            fb_addr_q   <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                ST_OFF: begin
                    if (INIT_START) begin
                        busy_q  <= 1'b1;
                        step_q  <= '0;
                        state_q <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    step_q <= step_q + 5'd1;
                    case (op)
                        OP_CMD: begin
                            tx_byte_q <= arg;
                            tx_dc_q   <= 1'b0;
                            ret_q     <= ST_INIT;
                            state_q   <= ST_SEND;
                        end
                        OP_DLY: begin
                            delay_q <= 32'(arg) * 32'(MS_CYCLES) - 32'd1;
                            state_q <= ST_DELAY;
                        end
                        OP_VDD_ON:  vddc_q  <= 1'b0;
                        OP_RES_LO:  res_q   <= 1'b0;
                        OP_RES_HI:  res_q   <= 1'b1;
                        OP_VBAT_ON: vbatc_q <= 1'b0;
                        default: begin
                            init_done_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_READY;
                        end
                    endcase
                end
                // Command bytes: byte, DC and enable all change in this one cycle.
                ST_SEND: begin
                    spi_data_q <= tx_byte_q;
                    dc_q       <= tx_dc_q;
                    spi_en_q   <= 1'b1;
                    state_q    <= ST_WAIT_FIN;
                end
                ST_WAIT_FIN: begin
                    if (SPI_FIN) begin
                        spi_en_q <= 1'b0;
                        state_q  <= ST_WAIT_REL;
                    end
                end
                // Leaving one cycle after FIN is seen low guarantees an idle
                // cycle with SPI_EN=0 before the next byte.
                ST_WAIT_REL: begin
                    if (!SPI_FIN) begin
                        state_q <= ret_q;
                        if (ret_q == ST_READY) begin
                            busy_q <= pending_d;
                        end
                    end
                end
                ST_DELAY: begin
                    if (delay_q == 32'd0) begin
                        state_q <= ST_INIT;
                    end else begin
                        delay_q <= delay_q - 32'd1;
                    end
                end
                ST_READY: begin
                    if (UPDATE_REQ || pending_q) begin
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                        page_q    <= '0;
                        hdr_q     <= '0;
                        state_q   <= ST_PG_HDR;
                    end
                end
                ST_PG_HDR: begin
                    tx_dc_q <= 1'b0;
                    hdr_q   <= hdr_q + 2'd1;
                    state_q <= ST_SEND;
                    case (hdr_q)
                        2'd0:    tx_byte_q <= 8'h22;
                        2'd1:    tx_byte_q <= 8'(page_q);
                        2'd2:    tx_byte_q <= 8'h00;
                        default: tx_byte_q <= 8'h10;
                    endcase
                    // Address for column 0 is presented while in FB_FETCH so
                    // the RAM data is ready when FB_SEND runs.
                    if (hdr_q == 2'd3) begin
                        col_q     <= '0;
                        fb_addr_q <= fb_addr_of(page_q, '0);
                        ret_q     <= ST_FB_FETCH;
                    end else begin
                        ret_q <= ST_PG_HDR;
                    end
                end
                ST_FB_FETCH: begin
                    state_q <= ST_FB_SEND;
                end
                ST_FB_SEND: begin
                    spi_data_q <= FB_DATA;
                    dc_q       <= 1'b1;
                    spi_en_q   <= 1'b1;
                    state_q    <= ST_WAIT_FIN;
                    if (col_q == CW'(COLS - 1)) begin
                        col_q <= '0;
                        hdr_q <= '0;
                        if (page_q == PW'(PAGES - 1)) begin
                            page_q <= '0;
                            ret_q  <= ST_READY;
                        end else begin
                            page_q <= page_q + PW'(1);
                            ret_q  <= ST_PG_HDR;
                        end
                    end else begin
                        col_q     <= col_q + CW'(1);
                        fb_addr_q <= fb_addr_of(page_q, col_q + CW'(1));
                        ret_q     <= ST_FB_FETCH;
                    end
                end
                default: state_q <= ST_OFF;
            endcase
        end
    end
endmodule

// File: tb/tb_oled_spi_sequencer.sv
// Testbench for oled_spi_sequencer: SPI sender model with randomized FIN latency
// and release hold, frame-buffer RAM model, byte capture monitor, and an expected
// byte stream built from the init script and the page/column frame layout.
module tb_oled_spi_sequencer;
    localparam int MS    = 10;
    localparam int PAGES = 4;
    localparam int COLS  = 128;
    localparam int FRAME = PAGES * (4 + COLS);

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       INIT_START = 1'b0;
    logic       UPDATE_REQ = 1'b0;
    logic       SPI_FIN = 1'b0;
    logic [7:0] FB_DATA;
    logic       BUSY, INIT_DONE, SPI_EN, DC, RES, VBATC, VDDC;
    logic [8:0] FB_ADDR;
    logic [7:0] SPI_DATA;

    always #5 CLK = ~CLK;

    oled_spi_sequencer #(.MS_CYCLES(MS), .PAGES(PAGES), .COLS(COLS)) dut (
        .CLK(CLK), .RST(RST), .INIT_START(INIT_START), .UPDATE_REQ(UPDATE_REQ),
        .BUSY(BUSY), .INIT_DONE(INIT_DONE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA),
        .SPI_EN(SPI_EN), .SPI_DATA(SPI_DATA), .SPI_FIN(SPI_FIN), .DC(DC),
        .RES(RES), .VBATC(VBATC), .VDDC(VDDC)
    );

    // Frame-buffer RAM, registered read.
    logic [7:0] fb [0:511];
    always @(posedge CLK) FB_DATA <= fb[FB_ADDR];

    // SPI sender model.
    int fin_lat = 4, stall_extra = 0, rel_hold = 0, lat_cnt = 0, rel_left = 0;
    always @(posedge CLK) begin
        if (SPI_EN) begin
            rel_left <= rel_hold;
            if (!SPI_FIN) begin
                if (lat_cnt >= fin_lat + stall_extra) SPI_FIN <= 1'b1;
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            lat_cnt <= 0;
            if (SPI_FIN) begin
                if (rel_left == 0) SPI_FIN <= 1'b0;
                else rel_left <= rel_left - 1;
            end
        end
    end

    // Monitor: captures {DC,byte} on each SPI_EN rise, checks stability/handshake.
    logic [8:0] cap_q [$];
    logic [8:0] cur_byte = '0;
    logic prev_en = 1'b0, prev_fin = 1'b0, prev_vbatc = 1'b1;
    int cyc = 0, res_low = 0, stab_err = 0, hs_err = 0, t_vbat = 0, t_81 = 0;
    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (SPI_EN && !prev_en) begin
            cap_q.push_back({DC, SPI_DATA});
            cur_byte <= {DC, SPI_DATA};
            if (prev_fin) hs_err <= hs_err + 1;
            if (!DC && SPI_DATA == 8'h81 && t_81 == 0) t_81 <= cyc;
        end else if (SPI_EN && ({DC, SPI_DATA} != cur_byte)) begin
            stab_err <= stab_err + 1;
        end
        if (RES === 1'b0) res_low <= res_low + 1;
        if (VBATC === 1'b0 && prev_vbatc) t_vbat <= cyc;
        prev_en    <= SPI_EN;
        prev_fin   <= SPI_FIN;
        prev_vbatc <= VBATC;
    end

    int n_total = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of the byte stream.
    logic [7:0] init_seq [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                  8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
    logic [8:0] exp_q [$];

    task automatic exp_init();
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, init_seq[i]});
    endtask

    task automatic exp_frame();
        exp_q.delete();
        for (int p = 0; p < PAGES; p++) begin
            exp_q.push_back(9'h022);
            exp_q.push_back(9'(p));
            exp_q.push_back(9'h000);
            exp_q.push_back(9'h010);
            for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, fb[p * COLS + c]});
        end
    endtask

    task automatic cmp_bytes(input int base, input string tag);
        int n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < cap_q.size()) begin
                check_eq($sformatf("%s[%0d]", tag, i), 32'(cap_q[base + i]), 32'(exp_q[i]));
                n++;
            end
        end
        $display("compare %s: %0d bytes from index %0d", tag, n, base);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_update();
        @(negedge CLK) UPDATE_REQ = 1'b1;
        @(negedge CLK) UPDATE_REQ = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        tick(2);
        while ((BUSY || SPI_EN) && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check_eq({tag, "_idle"}, {30'd0, BUSY, SPI_EN}, 32'd0);
    endtask

    task automatic wait_bytes(input int target, input int budget, input string tag);
        int k = 0;
        while (cap_q.size() < target && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check_eq({tag, "_reached"}, 32'(cap_q.size() >= target), 32'd1);
    endtask

    int base;

    initial begin
        // 1. Reset values and quiet idle.
        tick(3);
        check_eq("rst_spi_en", SPI_EN, 0);
        check_eq("rst_spi_data", SPI_DATA, 0);
        check_eq("rst_dc", DC, 0);
        check_eq("rst_pins", {RES, VBATC, VDDC}, 3'b111);
        check_eq("rst_busy_done", {BUSY, INIT_DONE}, 0);
        check_eq("rst_fb_addr", FB_ADDR, 0);
        RST = 1'b0;
        tick(20);
        check_eq("idle_no_bytes", cap_q.size(), 0);

        // Update before init is dropped.
        pulse_update();
        tick(30);
        check_eq("preinit_update_bytes", cap_q.size(), 0);
        check_eq("preinit_busy", BUSY, 0);

        // 2. Init, with a simultaneous update that must be ignored.
        @(negedge CLK) begin INIT_START = 1'b1; UPDATE_REQ = 1'b1; end
        @(negedge CLK) begin INIT_START = 1'b0; UPDATE_REQ = 1'b0; end
        check_eq("init_busy", BUSY, 1);
        wait_idle(5000, "init");
        exp_init();
        check_eq("init_count", cap_q.size(), 12);
        cmp_bytes(0, "init");
        check_eq("init_done", INIT_DONE, 1);
        check_eq("init_pins", {RES, VBATC, VDDC}, 3'b100);
        check_eq("res_low_ge10", 32'(res_low >= 10), 1);
        check_eq("vbat_before_81_ge1000", 32'(t_81 - t_vbat >= 1000), 1);
        tick(30);
        check_eq("init_no_frame", cap_q.size(), 12);
        @(negedge CLK) INIT_START = 1'b1;
        @(negedge CLK) INIT_START = 1'b0;
        tick(20);
        check_eq("reinit_ignored", {28'd0, BUSY, RES, VBATC, VDDC}, 32'b0100);
        check_eq("reinit_no_bytes", cap_q.size(), 12);

        // 3. One frame with FB[i] = i.
        for (int i = 0; i < 512; i++) fb[i] = 8'(i);
        base = cap_q.size();
        pulse_update();
        wait_idle(20000, "frame1");
        exp_frame();
        check_eq("frame1_count", cap_q.size(), base + FRAME);
        cmp_bytes(base, "frame1");
        if (cap_q.size() >= base + 137) begin
            check_eq("pg1_hdr", {cap_q[base + 132][7:0], cap_q[base + 133][7:0],
                                 cap_q[base + 134][7:0], cap_q[base + 135][7:0]}, 32'h22010010);
            check_eq("pg1_col0", 32'(cap_q[base + 136]), 32'h180);
        end
        check_eq("frame1_busy", BUSY, 0);

        // 4. Three requests during a frame coalesce into one extra frame.
        for (int i = 0; i < 512; i++) fb[i] = 8'($urandom);
        fin_lat  = $urandom_range(1, 6);
        rel_hold = $urandom_range(0, 3);
        base = cap_q.size();
        pulse_update();
        wait_bytes(base + 20, 2000, "coalesce_start");
        for (int r = 0; r < 3; r++) begin
            tick($urandom_range(5, 40));
            pulse_update();
        end
        wait_idle(40000, "coalesce");
        exp_frame();
        check_eq("coalesce_count", cap_q.size(), base + 2 * FRAME);
        cmp_bytes(base, "coalesce_f1");
        cmp_bytes(base + FRAME, "coalesce_f2");

        // 5. Stall FIN for 50 cycles mid-frame.
        for (int i = 0; i < 512; i++) fb[i] = 8'($urandom);
        fin_lat  = 4;
        rel_hold = 2;
        exp_frame();
        base = cap_q.size();
        pulse_update();
        wait_bytes(base + 50, 2000, "stall_start");
        stall_extra = 50;
        tick(45);
        check_eq("stall_en", {31'd0, SPI_EN}, 1);
        check_eq("stall_fin", {31'd0, SPI_FIN}, 0);
        check_eq("stall_data", {23'd0, DC, SPI_DATA}, 32'(exp_q[49]));
        check_eq("stall_no_new", cap_q.size(), base + 50);
        stall_extra = 0;
        wait_idle(20000, "stall");
        check_eq("stall_count", cap_q.size(), base + FRAME);
        cmp_bytes(base, "stall_frame");

        // 6. Reset in the middle of page 2.
        fin_lat  = $urandom_range(1, 6);
        rel_hold = $urandom_range(0, 3);
        base = cap_q.size();
        pulse_update();
        wait_bytes(base + 2 * (4 + COLS) + 70, 20000, "midreset_start");
        RST = 1'b1;
        tick(1);
        check_eq("midrst_spi_en", SPI_EN, 0);
        check_eq("midrst_flags", {BUSY, INIT_DONE}, 0);
        check_eq("midrst_pins", {RES, VBATC, VDDC}, 3'b111);
        RST = 1'b0;
        base = cap_q.size();
        tick(20);
        check_eq("midrst_no_bytes", cap_q.size(), base);
        check_eq("midrst_off_busy", BUSY, 0);

        check_eq("data_stable_while_en", stab_err, 0);
        check_eq("en_after_fin_release", hs_err, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1);
    end
endmodule
